perceptron_bpred_gen: RTL
=========================

Name: perceptron_bpred_gen

Overview:
- Parametrised perceptron direction predictor for the fetch stage; next generation of the fixed 12-history / 64-entry predictor.
- Generalised in history length, weight width and table depth. Adds a bias weight, threshold training, saturating updates and a speculative global history register (GHR) with misprediction recovery.
- Adds a power-on table-clear FSM and update read-modify-write forwarding.
- Sits between fetch PC generation and execute branch resolution.

Parameters:
- HIST_LEN, 12, global history bits = non-bias weights per entry
- WEIGHT_W, 8, signed weight width (two's complement)
- INDEX_W, 6, table index bits; depth = 2**INDEX_W; index = pc[INDEX_W+1:2]
- THETA, 37, training threshold (floor(1.93*HIST_LEN+14))
- SUM_W, WEIGHT_W+$clog2(HIST_LEN+2), signed dot-product width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- lu_valid  in  1  lookup request
- lu_ready  out  1  predictor can accept lookups (low during INIT)
- lu_pc  in  32  fetch PC
- pred_valid  out  1  prediction result valid
- pred_dir  out  1  1 = taken
- pred_sum  out  SUM_W  signed dot product, carried down the pipe for training
- pred_ghr  out  HIST_LEN  history used for this prediction (checkpoint)
- up_valid  in  1  resolved branch update
- up_pc  in  32  branch PC
- up_ghr  in  HIST_LEN  checkpoint returned with branch
- up_sum  in  SUM_W  sum returned with branch
- up_dir  in  1  actual direction
- up_mispred  in  1  predicted direction was wrong
- ghr_out  out  HIST_LEN  current speculative GHR (debug)

Behaviour:
- Reset: state INIT, init index 0, GHR 0, lu_ready 0, pred_valid 0, pred_dir 0, pred_sum 0, pred_ghr 0, update pipe cleared.
- Reset asserted mid-INIT or mid-RUN restarts INIT from index 0.
- FSM INIT:
  - Writes all-zero weights (bias + HIST_LEN) to one index per cycle, 0..2**INDEX_W-1.
  - After the last write, moves to RUN.
  - INIT takes exactly 2**INDEX_W cycles after reset deasserts.
  - up_valid is ignored during INIT. lu_valid with lu_ready=0 is dropped.
- FSM RUN: lu_ready=1; no other transitions.
- Lookup latency is 2 cycles:
  - lu_valid at cycle t: table read is registered at t+1, together with the GHR value sampled at t.
  - At t+2: pred_valid=1, pred_sum = w0 + sum_i(GHR[i] ? w_i : -w_i), and pred_dir = (pred_sum >= 0).
  - Fully pipelined: one lookup per cycle.
- Speculative GHR:
  - On each pred_valid, GHR <= {GHR[HIST_LEN-2:0], pred_dir}.
  - Lookups already in flight use the history from their issue cycle.
- Recovery:
  - When up_valid && up_mispred: GHR <= {up_ghr[HIST_LEN-2:0], up_dir}.
  - Recovery has priority over a same-cycle speculative shift.
  - Predictions in flight at recovery still emit. Fetch squashes them.
- Training trigger: up_valid && (up_mispred || |up_sum| <= THETA).
- Update pipeline:
  - U1 reads the entry at up_pc index.
  - U2 computes and writes:
    - w0 += up_dir ? +1 : -1
    - w_i += (up_ghr[i] == up_dir) ? +1 : -1
  - Each add saturates to [-2**(WEIGHT_W-1), 2**(WEIGHT_W-1)-1].
  - One update accepted per cycle.
- Hazard forwarding: if U1 and U2 target the same index, U1 takes U2's write data, not the stale table read. Back-to-back updates to one index accumulate correctly.
- Lookup/write same index, same cycle: the lookup returns the pre-write weights (read-before-write). This is a defined behaviour, not a bug.
- Lookup and update use independent read ports. The write port is shared with INIT, and INIT is exclusive with RUN.

Decomposition:
- Package perceptron_pkg holds:
  - the weight_t typedef (signed WEIGHT_W),
  - the entry_t typedef (array of HIST_LEN+1 weight_t),
  - the SUM_W function,
  - the THETA default function,
  - sat_inc/sat_dec functions.
- Sub-module perceptron_sum: combinational adder tree, entry_t and GHR in, signed SUM_W sum out, registered at its output by the parent.

Test Plan:
- Reset with INDEX_W=6: lu_ready low for exactly 64 cycles, then high. Every entry reads 0; the first lookup gives pred_sum=0, pred_dir=1.
- Train index of pc 0x40 with 5 taken updates (up_ghr=0xFFF, up_sum=0, up_mispred=0): every weight reaches +5; lookup with GHR=0xFFF gives pred_sum=65.
- 200 taken updates with up_sum=0 on one index: all weights saturate at +127 (no wrap to -128). No write occurs when |up_sum|=38 > THETA and mispred=0.
- Back-to-back updates on consecutive cycles to the same index, dir 1 then 1: weights +2, proving forwarding; repeat with different indices: each +1.
- Same cycle pred_valid (pred_dir=1) and recovery with up_ghr=0x005, up_dir=0: GHR=0x00A afterwards.
- Assert reset for 1 cycle at INIT index 20: INIT restarts at 0, and lu_ready rises 64 cycles after reset deasserts.

Source files
------------

// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
// Shared types and helpers for the perceptron branch direction predictor.
//   weight_t / entry_t : default-sized weight and table-entry types
//   bpred_state_t      : table-clear / run state of the predictor
//   sum_width()        : signed dot-product width for a given geometry
//   theta_default()    : training threshold floor(1.93*HIST_LEN + 14)
//   sat_inc/sat_dec()  : saturating +1 / -1 on a WEIGHT_W two's-complement weight
// -----------------------------------------------------------------------------
package perceptron_pkg;

   localparam int DEF_HIST_LEN = 12;
   localparam int DEF_WEIGHT_W = 8;
   localparam int DEF_INDEX_W  = 6;

   typedef logic signed [DEF_WEIGHT_W-1:0] weight_t;
   // Entry layout: element 0 is the bias weight, element i+1 pairs with GHR bit i.
   typedef weight_t entry_t [DEF_HIST_LEN+1];

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bpred_state_t;

   // Worst case |sum| is (HIST_LEN+1) * 2**(WEIGHT_W-1), plus one sign bit.
   function automatic int sum_width(input int hist_len, input int weight_w);
      return weight_w + $clog2(hist_len + 2);
   endfunction

   // Integer form of floor(1.93*h + 14).
   function automatic int theta_default(input int hist_len);
      return (193 * hist_len) / 100 + 14;
   endfunction

   function automatic int sat_inc(input int w, input int weight_w);
      int w_max;
      w_max = (1 << (weight_w - 1)) - 1;
      return (w >= w_max) ? w_max : w + 1;
   endfunction

   function automatic int sat_dec(input int w, input int weight_w);
      int w_min;
      w_min = -(1 << (weight_w - 1));
      return (w <= w_min) ? w_min : w - 1;
   endfunction

endpackage

// File: rtl/perceptron_sum.sv
// -----------------------------------------------------------------------------
// perceptron_sum
// Combinational perceptron dot product: bias + sum(GHR[i] ? w[i+1] : -w[i+1]).
// The parent registers the result.
//   entry : packed weights, bias in the low WEIGHT_W bits, weight i+1 above it
//   ghr   : history bits paired with the non-bias weights
//   sum   : signed SUM_W result
// -----------------------------------------------------------------------------
module perceptron_sum
   import perceptron_pkg::*;
#(
   parameter int HIST_LEN = DEF_HIST_LEN,
   parameter int WEIGHT_W = DEF_WEIGHT_W,
   parameter int SUM_W    = sum_width(HIST_LEN, WEIGHT_W)
)(
   input  logic [(HIST_LEN+1)*WEIGHT_W-1:0] entry,
   input  logic [HIST_LEN-1:0]              ghr,
   output logic [SUM_W-1:0]                 sum
);

   logic signed [SUM_W-1:0] term [HIST_LEN+1];
   logic signed [SUM_W-1:0] acc;

   genvar gi;
   generate
      for (gi = 0; gi <= HIST_LEN; gi++) begin : g_term
         logic signed [WEIGHT_W-1:0] w;
         assign w = entry[gi*WEIGHT_W +: WEIGHT_W];
         if (gi == 0) begin : g_bias
            assign term[gi] = SUM_W'(w);
         end else begin : g_hist
            assign term[gi] = ghr[gi-1] ? SUM_W'(w) : -SUM_W'(w);
         end
      end
   endgenerate

   // Written as a chain; synthesis balances it into a tree.
   always_comb begin
      acc = '0;
      for (int i = 0; i <= HIST_LEN; i++) begin
         acc = acc + term[i];
      end
   end

   assign sum = acc;

endmodule

// File: rtl/perceptron_bpred_gen.sv
// -----------------------------------------------------------------------------
// perceptron_bpred_gen
// Parametrised perceptron branch direction predictor with bias weight,
// threshold training, saturating weights, speculative GHR with recovery,
// power-on table clear and update read-modify-write forwarding.
//   clk, reset             : clock, synchronous active-high reset
//   lu_valid/lu_ready/lu_pc: lookup request (dropped while lu_ready is low)
//   pred_valid/dir/sum/ghr : prediction two cycles after an accepted lookup
//   up_valid/pc/ghr/sum/
//   up_dir/up_mispred      : resolved branch, trains and/or repairs the GHR
//   ghr_out                : current speculative GHR
// -----------------------------------------------------------------------------
module perceptron_bpred_gen
   import perceptron_pkg::*;
#(
   parameter int HIST_LEN = DEF_HIST_LEN,
   parameter int WEIGHT_W = DEF_WEIGHT_W,
   parameter int INDEX_W  = DEF_INDEX_W,
   parameter int THETA    = theta_default(HIST_LEN),
   parameter int SUM_W    = sum_width(HIST_LEN, WEIGHT_W)
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                lu_valid,
   output logic                lu_ready,
   input  logic [31:0]         lu_pc,
   output logic                pred_valid,
   output logic                pred_dir,
   output logic [SUM_W-1:0]    pred_sum,
   output logic [HIST_LEN-1:0] pred_ghr,
   input  logic                up_valid,
   input  logic [31:0]         up_pc,
   input  logic [HIST_LEN-1:0] up_ghr,
   input  logic [SUM_W-1:0]    up_sum,
   input  logic                up_dir,
   input  logic                up_mispred,
   output logic [HIST_LEN-1:0] ghr_out
);

   localparam int DEPTH   = 2**INDEX_W;
   localparam int ENTRY_W = (HIST_LEN+1)*WEIGHT_W;

   // ---------------- table-clear / run FSM ----------------
   bpred_state_t       state_reg, state_next;
   logic [INDEX_W-1:0] init_idx_reg;
   logic               init_we;
   logic               run;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_INIT;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_INIT: if (&init_idx_reg) state_next = ST_RUN;
         ST_RUN:  state_next = ST_RUN;
      endcase
   end

   always_comb begin
      lu_ready = 1'b0;
      init_we  = 1'b0;
      case (state_reg)
         ST_INIT: init_we  = 1'b1;
         ST_RUN:  lu_ready = 1'b1;
      endcase
   end

   assign run = (state_reg == ST_RUN);

   always_ff @(posedge clk) begin
      if (reset)        init_idx_reg <= '0;
      else if (init_we) init_idx_reg <= init_idx_reg + INDEX_W'(1);
   end

   // ---------------- weight table ----------------
   // Two registered read ports (lookup, update) and one write port shared by
   // the table clear and the update pipe. A read and write to the same index
   // on the same edge returns the old weights.
   logic [ENTRY_W-1:0] table_mem [DEPTH];
   logic [ENTRY_W-1:0] lu_entry_reg, up_entry_reg;
   logic               wr_en;
   logic [INDEX_W-1:0] wr_idx;
   logic [ENTRY_W-1:0] wr_data;
   logic [INDEX_W-1:0] lu_idx, up_idx;

   assign lu_idx = lu_pc[INDEX_W+1:2];
   assign up_idx = up_pc[INDEX_W+1:2];

   always_ff @(posedge clk) begin
      if (wr_en) table_mem[wr_idx] <= wr_data;
      lu_entry_reg <= table_mem[lu_idx];
      up_entry_reg <= table_mem[up_idx];
   end

   // ---------------- lookup pipe ----------------
   logic                lu_v_reg;
   logic [HIST_LEN-1:0] lu_ghr_reg;
   logic [SUM_W-1:0]    sum_comb;
   logic                pred_valid_reg, pred_dir_reg;
   logic [SUM_W-1:0]    pred_sum_reg;
   logic [HIST_LEN-1:0] pred_ghr_reg;
   logic [HIST_LEN-1:0] ghr_reg;

   perceptron_sum #(
      .HIST_LEN (HIST_LEN),
      .WEIGHT_W (WEIGHT_W),
      .SUM_W    (SUM_W)
   ) u_sum (
      .entry (lu_entry_reg),
      .ghr   (lu_ghr_reg),
      .sum   (sum_comb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         lu_v_reg       <= 1'b0;
         lu_ghr_reg     <= '0;
         pred_valid_reg <= 1'b0;
         pred_dir_reg   <= 1'b0;
         pred_sum_reg   <= '0;
         pred_ghr_reg   <= '0;
      end else begin
         lu_v_reg       <= lu_valid & lu_ready;
         lu_ghr_reg     <= ghr_reg;
         pred_valid_reg <= lu_v_reg;
         if (lu_v_reg) begin
            pred_sum_reg <= sum_comb;
            pred_dir_reg <= ~sum_comb[SUM_W-1];
            pred_ghr_reg <= lu_ghr_reg;
         end
      end
   end

   assign pred_valid = pred_valid_reg;
   assign pred_dir   = pred_dir_reg;
   assign pred_sum   = pred_sum_reg;
   assign pred_ghr   = pred_ghr_reg;

   // ---------------- speculative GHR ----------------
   // Recovery wins over a same-cycle speculative shift.
   logic recover;
   assign recover = up_valid & up_mispred & run;

   always_ff @(posedge clk) begin
      if (reset)               ghr_reg <= '0;
      else if (recover)        ghr_reg <= {up_ghr[HIST_LEN-2:0], up_dir};
      else if (pred_valid_reg) ghr_reg <= {ghr_reg[HIST_LEN-2:0], pred_dir_reg};
   end

   assign ghr_out = ghr_reg;

   // ---------------- update pipe ----------------
   int   up_sum_int;
   logic train;
   assign up_sum_int = int'($signed(up_sum));
   assign train = up_valid & run &
                  (up_mispred | ((up_sum_int <= THETA) && (up_sum_int >= -THETA)));

   logic                u2_v_reg, u2_dir_reg, u2_fwd_reg;
   logic [INDEX_W-1:0]  u2_idx_reg;
   logic [HIST_LEN-1:0] u2_ghr_reg;
   logic [ENTRY_W-1:0]  u2_fwd_data_reg;
   logic [ENTRY_W-1:0]  u2_entry;
   logic [ENTRY_W-1:0]  upd_data;

   // When the read issued this edge hits the index being written on the same
   // edge, the table read is stale; capture the write data instead.
   always_ff @(posedge clk) begin
      if (reset) begin
         u2_v_reg   <= 1'b0;
         u2_fwd_reg <= 1'b0;
      end else begin
         u2_v_reg   <= train;
         u2_fwd_reg <= u2_v_reg && (u2_idx_reg == up_idx);
      end
      u2_idx_reg      <= up_idx;
      u2_ghr_reg      <= up_ghr;
      u2_dir_reg      <= up_dir;
      u2_fwd_data_reg <= upd_data;
   end

   assign u2_entry = u2_fwd_reg ? u2_fwd_data_reg : up_entry_reg;

   genvar gi;
   generate
      for (gi = 0; gi <= HIST_LEN; gi++) begin : g_upd
         logic                       inc;
         logic signed [WEIGHT_W-1:0] w_old;
         if (gi == 0) begin : g_bias
            assign inc = u2_dir_reg;
         end else begin : g_hist
            assign inc = (u2_ghr_reg[gi-1] == u2_dir_reg);
         end
         assign w_old = u2_entry[gi*WEIGHT_W +: WEIGHT_W];
         assign upd_data[gi*WEIGHT_W +: WEIGHT_W] =
            inc ? WEIGHT_W'(sat_inc(int'(w_old), WEIGHT_W))
                : WEIGHT_W'(sat_dec(int'(w_old), WEIGHT_W));
      end
   endgenerate

   // Table clear and training never overlap: training needs the RUN state.
   always_comb begin
      wr_en   = init_we | u2_v_reg;
      wr_idx  = init_we ? init_idx_reg : u2_idx_reg;
      wr_data = init_we ? '0 : upd_data;
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{lu_pc[31:INDEX_W+2], lu_pc[1:0],
                             up_pc[31:INDEX_W+2], up_pc[1:0]};

endmodule
